// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Wishbone pipeline master that runs one ALU operation per command against
// the 8-bit alu_wb slave: write A, write B, read the result at address op,
// then return the result on a valid/ready response port. Each bus phase has
// a cycle budget (TIMEOUT); when it runs out the command is aborted and
// reported with o_rsp_err=1 and data 8'h00.
//
// Ports:
//   i_clk, reset              clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake; i_cmd_a, i_cmd_b, i_cmd_op
//   o_rsp_valid/i_rsp_ready   response handshake; o_rsp_data, o_rsp_err
//   o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data    bus request
//   i_wb_ack, i_wb_stall, i_wb_data                      bus reply
module alu_op_sequencer #(
   parameter int         TIMEOUT = 15,
   parameter logic [7:0] ADDR_A  = 8'h00,
   parameter logic [7:0] ADDR_B  = 8'h01
) (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [7:0] i_cmd_a,
   input  logic [7:0] i_cmd_b,
   input  logic [7:0] i_cmd_op,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_err,
   output logic       o_wb_cyc,
   output logic       o_wb_stb,
   output logic       o_wb_we,
   output logic [7:0] o_wb_addr,
   output logic [7:0] o_wb_data,
   input  logic       i_wb_ack,
   input  logic       i_wb_stall,
   input  logic [7:0] i_wb_data
);

   typedef enum logic [2:0] {
      IDLE, WR_A, WAIT_A, WR_B, WAIT_B, RD_OP, WAIT_R, DONE
   } state_t;

   // Abort fires on the edge that would complete the TIMEOUT-th phase cycle.
   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic       armed;      // low during reset and until the first edge after it
   logic [7:0] a_q, b_q, op_q;
   logic [7:0] cnt;
   logic [7:0] cnt_inc;
   logic       in_phase, in_wait, expired;

   assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign expired  = (cnt >= LIMIT);
   assign in_phase = (state != IDLE) && (state != DONE);
   assign in_wait  = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_R);

   assign o_cmd_ready = armed && (state == IDLE);

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         armed       <= 1'b0;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         op_q        <= 8'h00;
         cnt         <= 8'h00;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= 8'h00;
         o_rsp_err   <= 1'b0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_we     <= 1'b0;
         o_wb_addr   <= 8'h00;
         o_wb_data   <= 8'h00;
      end else begin
         armed <= 1'b1;
         // An ack in a WAIT state wins over an abort on the same edge.
         if (in_phase && !(in_wait && i_wb_ack) && expired) begin
            state       <= DONE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_data  <= 8'h00;
         end else begin
            case (state)
               IDLE: begin
                  if (i_cmd_valid && o_cmd_ready) begin
                     a_q       <= i_cmd_a;
                     b_q       <= i_cmd_b;
                     op_q      <= i_cmd_op;
                     cnt       <= 8'h00;
                     state     <= WR_A;
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b1;
                     o_wb_addr <= ADDR_A;
                     o_wb_data <= i_cmd_a;
                  end
               end
               WR_A, WR_B, RD_OP: begin
                  cnt <= cnt_inc;
                  if (!i_wb_stall) begin
                     o_wb_stb <= 1'b0;
                     case (state)
                        WR_A:    state <= WAIT_A;
                        WR_B:    state <= WAIT_B;
                        default: state <= WAIT_R;
                     endcase
                  end
               end
               WAIT_A: begin
                  if (i_wb_ack) begin
                     cnt       <= 8'h00;
                     state     <= WR_B;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b1;
                     o_wb_addr <= ADDR_B;
                     o_wb_data <= b_q;
                  end else cnt <= cnt_inc;
               end
               WAIT_B: begin
                  if (i_wb_ack) begin
                     cnt       <= 8'h00;
                     state     <= RD_OP;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b0;
                     o_wb_addr <= op_q;
                     o_wb_data <= 8'h00;
                  end else cnt <= cnt_inc;
               end
               WAIT_R: begin
                  if (i_wb_ack) begin
                     state       <= DONE;
                     o_wb_cyc    <= 1'b0;
                     o_rsp_valid <= 1'b1;
                     o_rsp_err   <= 1'b0;
                     o_rsp_data  <= i_wb_data;
                  end else cnt <= cnt_inc;
               end
               DONE: begin
                  if (i_rsp_ready) begin
                     state       <= IDLE;
                     o_rsp_valid <= 1'b0;
                     o_rsp_err   <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural alu_wb slave (ack one cycle after
// acceptance), a posedge monitor that scoreboards bus requests and responses
// queued at command acceptance, a vector table plus hand-written corner cases.
module tb_alu_op_sequencer;

   logic       i_clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic [7:0] i_cmd_a = 8'h00, i_cmd_b = 8'h00, i_cmd_op = 8'h00;
   logic       o_rsp_valid;
   logic       i_rsp_ready = 1'b1;
   logic [7:0] o_rsp_data;
   logic       o_rsp_err;
   logic       o_wb_cyc, o_wb_stb, o_wb_we;
   logic [7:0] o_wb_addr, o_wb_data;
   logic       i_wb_ack;
   logic       i_wb_stall = 1'b0;
   logic [7:0] i_wb_data;

   alu_op_sequencer #(.TIMEOUT(15), .ADDR_A(8'h00), .ADDR_B(8'h01)) dut (
      .i_clk(i_clk), .reset(reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [7:0] op);
      case (op)
         8'h80:   return x + y;
         8'h81:   return x + y + 8'd1;
         8'h82:   return x ^ y;
         8'h83:   return x & y;
         default: return 8'h00;
      endcase
   endfunction

   logic [7:0] ra = 8'h00, rb = 8'h00, slv_rdata = 8'h00;
   logic       slv_ack = 1'b0;
   logic       ack_en = 1'b1;
   logic       stray = 1'b0;

   assign i_wb_ack  = slv_ack | stray;
   assign i_wb_data = slv_rdata;

   always @(posedge i_clk) begin
      slv_ack <= 1'b0;
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
         if (o_wb_we) begin
            if (o_wb_addr == 8'h00) ra <= o_wb_data;
            else if (o_wb_addr == 8'h01) rb <= o_wb_data;
         end else slv_rdata <= alu(ra, rb, o_wb_addr);
         slv_ack <= ack_en;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } bus_t;
   typedef struct { logic [7:0] data; logic err; int lat; } rsp_t;
   bus_t bus_q[$];
   rsp_t rsp_q[$];

   // Expectations for the next accepted command, set by the stimulus.
   logic [7:0] exp_data = 8'h00;
   logic       exp_err = 1'b0;
   int         exp_phases = 3;
   int         exp_lat = 7;

   int cyc = 0;
   int accept_cyc = 0, accept_count = 0, hs_cyc = 0, rsp_count = 0;

   always @(negedge i_clk) cyc++;

   always @(posedge i_clk) begin
      bus_t b;
      rsp_t r;
      if (reset) begin
         bus_q.delete();
         rsp_q.delete();
      end else begin
         if (i_cmd_valid && o_cmd_ready) begin
            accept_cyc = cyc;
            accept_count++;
            bus_q.push_back('{1'b1, 8'h00, i_cmd_a});
            if (exp_phases == 3) begin
               bus_q.push_back('{1'b1, 8'h01, i_cmd_b});
               bus_q.push_back('{1'b0, i_cmd_op, 8'h00});
            end
            rsp_q.push_back('{exp_data, exp_err, exp_lat});
         end
         if (o_wb_stb) begin
            if (bus_q.size() == 0) chk("unexpected_stb", 32'(o_wb_stb), 32'd0);
            else if (i_wb_stall)
               chk("stall_hold", {o_wb_we, o_wb_addr, o_wb_data},
                   {bus_q[0].we, bus_q[0].addr, bus_q[0].data});
            else begin
               b = bus_q.pop_front();
               chk("bus_req", {o_wb_cyc, o_wb_we, o_wb_addr, o_wb_data},
                   {1'b1, b.we, b.addr, b.data});
            end
         end
         if (o_rsp_valid && i_rsp_ready) begin
            hs_cyc = cyc;
            rsp_count++;
            if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
            else begin
               r = rsp_q.pop_front();
               chk("rsp_data", 32'(o_rsp_data), 32'(r.data));
               chk("rsp_err", 32'(o_rsp_err), 32'(r.err));
               chk("rsp_bus_idle", {o_wb_cyc, o_wb_stb}, 2'b00);
               if (r.lat >= 0) chk("rsp_latency", cyc - accept_cyc, r.lat);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] d, input logic e, input int ph, input int lat);
      int start;
      start = accept_count;
      exp_data = d; exp_err = e; exp_phases = ph; exp_lat = lat;
      i_cmd_a = a; i_cmd_b = b; i_cmd_op = op; i_cmd_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         if (accept_count != start) break;
      end
      if (accept_count == start) chk("accept_wait", accept_count, start + 1);
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int tgt);
      for (int k = 0; k < 200; k++) begin
         if (rsp_count >= tgt) break;
         @(negedge i_clk);
      end
      if (rsp_count < tgt) chk("rsp_wait", rsp_count, tgt);
   endtask

   task automatic wait_bus(input logic stb, input logic [7:0] addr);
      int k;
      for (k = 0; k < 40; k++) begin
         if (o_wb_cyc && o_wb_stb == stb && o_wb_addr == addr) break;
         @(negedge i_clk);
      end
      if (k == 40) chk("bus_wait", 32'(o_wb_addr), 32'(addr));
   endtask

   typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] op; logic [7:0] res; } vec_t;
   vec_t vecs[6];

   initial begin
      int tgt, prev;
      vecs[0] = '{8'h12, 8'h34, 8'h80, 8'h46};
      vecs[1] = '{8'hFF, 8'h01, 8'h80, 8'h00};
      vecs[2] = '{8'hF0, 8'h0F, 8'h82, 8'hFF};
      vecs[3] = '{8'h3C, 8'hF0, 8'h83, 8'h30};
      vecs[4] = '{8'h7F, 8'h7F, 8'h80, 8'hFE};
      vecs[5] = '{8'hAA, 8'h55, 8'h81, 8'h00};
      tgt = 0;
      prev = 0;

      // reset state
      #2;
      chk("reset_outputs", {o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_wb_cyc,
                            o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 30'd0);
      repeat (2) @(negedge i_clk);
      reset = 1'b0;
      #1 chk("ready_after_release", 32'(o_cmd_ready), 32'd0);
      @(negedge i_clk);
      chk("ready_first_edge", 32'(o_cmd_ready), 32'd1);

      // stray ack in IDLE
      stray = 1'b1;
      @(negedge i_clk);
      stray = 1'b0;
      chk("stray_idle", {o_cmd_ready, o_wb_cyc, o_rsp_valid}, 3'b100);

      // vector table, command valid held across commands
      i_cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int start;
         start = accept_count;
         exp_data = vecs[i].res; exp_err = 1'b0; exp_phases = 3; exp_lat = 7;
         i_cmd_a = vecs[i].a; i_cmd_b = vecs[i].b; i_cmd_op = vecs[i].op;
         for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (accept_count != start) break;
         end
         if (accept_count == start) chk("accept_wait", accept_count, start + 1);
         if (i > 0) chk("cmd_period", accept_cyc - prev, 8);
         prev = accept_cyc;
         tgt++;
      end
      i_cmd_valid = 1'b0;
      wait_rsp(tgt);

      // stray ack while WR_A is stalled
      send(8'h12, 8'h34, 8'h80, 8'h46, 1'b0, 3, 9);
      i_wb_stall = 1'b1; stray = 1'b1;
      @(negedge i_clk);
      stray = 1'b0;
      @(negedge i_clk);
      i_wb_stall = 1'b0;
      tgt++; wait_rsp(tgt);

      // 3-cycle stall on WR_B
      send(8'h12, 8'h34, 8'h80, 8'h46, 1'b0, 3, 10);
      wait_bus(1'b1, 8'h01);
      i_wb_stall = 1'b1;
      repeat (3) @(negedge i_clk);
      i_wb_stall = 1'b0;
      tgt++; wait_rsp(tgt);

      // timeout: slave never acks the A write
      ack_en = 1'b0;
      send(8'h5A, 8'h22, 8'h80, 8'h00, 1'b1, 1, 16);
      tgt++; wait_rsp(tgt);
      ack_en = 1'b1;
      repeat (3) @(negedge i_clk);

      // backpressure with a second command pending
      i_rsp_ready = 1'b0;
      send(8'h21, 8'h05, 8'h80, 8'h26, 1'b0, 3, -1);
      for (int k = 0; k < 30 && !o_rsp_valid; k++) @(negedge i_clk);
      exp_data = 8'h4F; exp_err = 1'b0; exp_phases = 3; exp_lat = 7;
      i_cmd_a = 8'h40; i_cmd_b = 8'h0F; i_cmd_op = 8'h82; i_cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold", {o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready}, {1'b1, 8'h26, 1'b0, 1'b0});
         @(negedge i_clk);
      end
      prev = accept_count;
      i_rsp_ready = 1'b1;
      for (int k = 0; k < 10 && accept_count == prev; k++) @(negedge i_clk);
      i_cmd_valid = 1'b0;
      chk("bp_accept_after_hs", accept_cyc - hs_cyc, 1);
      tgt += 2; wait_rsp(tgt);

      // asynchronous reset in WAIT_B, then a normal command
      send(8'h11, 8'h22, 8'h80, 8'h33, 1'b0, 3, -1);
      wait_bus(1'b0, 8'h01);
      #1 reset = 1'b1;
      #1 chk("reset_midop", {o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_wb_cyc,
                             o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 30'd0);
      repeat (2) @(negedge i_clk);
      reset = 1'b0;
      #1 chk("ready_after_midop_release", 32'(o_cmd_ready), 32'd0);
      @(negedge i_clk);
      send(8'hFF, 8'h01, 8'h80, 8'h00, 1'b0, 3, 7);
      tgt++; wait_rsp(tgt);
      repeat (20) @(negedge i_clk);
      chk("rsp_total", rsp_count, tgt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
